// File: rtl/mem_port_if.sv
// mem_port_if: bundles the CPU-side memory port and the SRAM-side strobes of
// mem_port_ctrl.
//   CPU side : mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
//              mem_rdata, mem_resp
//   SRAM side: sram_addr, sram_ce, sram_we, sram_be, sram_wdata, sram_rdata
// Modports:
//   slave  - the controller (consumes CPU requests and SRAM read data)
//   master - the environment (CPU plus SRAM)
interface mem_port_if;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic [14:0] sram_addr;
    logic        sram_ce;
    logic        sram_we;
    logic [1:0]  sram_be;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, sram_rdata,
        output mem_rdata, mem_resp, sram_addr, sram_ce, sram_we, sram_be, sram_wdata
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, sram_rdata,
        input  mem_rdata, mem_resp, sram_addr, sram_ce, sram_we, sram_be, sram_wdata
    );
endinterface

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: bridges the LC-3b memory port to a single-port synchronous
// SRAM with WAIT_STATES extra cycles per access. Each request is latched in
// IDLE, the SRAM strobes are held stable through ACCESS, read data is captured
// on the last ACCESS cycle and a one-cycle mem_resp is returned in RESP.
// Ports:
//   clk    - system clock, all state on posedge
//   reset  - synchronous active-high reset
//   bus    - mem_port_if.slave (CPU request/response and SRAM strobes)
// Parameters:
//   WAIT_STATES - extra SRAM cycles per access beyond the first (0..15)
// Build option:
//   MEM_PORT_POSTED_WRITE_EN - writes respond on the first ACCESS cycle and
//   finish in the background, returning straight to IDLE.
module mem_port_ctrl #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic       clk,
    input  logic       reset,
    mem_port_if.slave  bus
);
    localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [14:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [1:0]       be_q, be_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             access;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (bus.mem_read || bus.mem_write) begin
                    addr_d  = bus.mem_address[15:1];
                    // A simultaneous read wins; the write is dropped.
                    we_d    = bus.mem_write & ~bus.mem_read;
                    be_d    = bus.mem_read ? 2'b11 : bus.mem_byte_enable;
                    wdata_d = bus.mem_wdata;
                    cnt_d   = CntLoad;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_d = bus.sram_rdata;
                    end
`ifdef MEM_PORT_POSTED_WRITE_EN
                    // Posted writes already responded; skip RESP.
                    state_d = we_q ? StIdle : StResp;
`else
                    state_d = StResp;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                // The strobe still high here belongs to the completing request.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign access = (state_q == StAccess);

    always_comb begin
        bus.sram_ce    = access;
        bus.sram_addr  = access ? addr_q : '0;
        bus.sram_we    = access & we_q;
        bus.sram_be    = access ? be_q : '0;
        bus.sram_wdata = access ? wdata_q : '0;
        bus.mem_rdata  = rdata_q;
`ifdef MEM_PORT_POSTED_WRITE_EN
        // The counter still holds its load value only on the first ACCESS cycle.
        bus.mem_resp   = (state_q == StResp) || (access && we_q && (cnt_q == CntLoad));
`else
        bus.mem_resp   = (state_q == StResp);
`endif
    end
endmodule

// File: tb/tb_mem_port_ctrl.sv
module tb_mem_port_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_port_if bus_a ();
    mem_port_if bus_b ();

    mem_port_ctrl #(.WAIT_STATES(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    mem_port_ctrl #(.WAIT_STATES(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.mem_address = '0; bus_a.mem_read = 0; bus_a.mem_write = 0;
        bus_a.mem_byte_enable = '0; bus_a.mem_wdata = '0; bus_a.sram_rdata = '0;
        bus_b.mem_address = '0; bus_b.mem_read = 0; bus_b.mem_write = 0;
        bus_b.mem_byte_enable = '0; bus_b.mem_wdata = '0; bus_b.sram_rdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        n_vec++;
        if ({bus_a.sram_ce, bus_a.sram_we, bus_a.sram_be, bus_a.sram_addr, bus_a.sram_wdata,
             bus_a.mem_resp, bus_a.mem_rdata} !== 52'h0) begin
            n_err++;
            $display("FAIL reset_a: outputs got %h required 0", {bus_a.sram_ce, bus_a.sram_we,
                     bus_a.sram_be, bus_a.sram_addr, bus_a.sram_wdata, bus_a.mem_resp,
                     bus_a.mem_rdata});
        end
        n_vec++;
        if ({bus_b.sram_ce, bus_b.sram_we, bus_b.sram_be, bus_b.sram_addr, bus_b.sram_wdata,
             bus_b.mem_resp, bus_b.mem_rdata} !== 52'h0) begin
            n_err++;
            $display("FAIL reset_b: outputs got %h required 0", {bus_b.sram_ce, bus_b.sram_we,
                     bus_b.sram_be, bus_b.sram_addr, bus_b.sram_wdata, bus_b.mem_resp,
                     bus_b.mem_rdata});
        end
        reset = 1'b0;
        step();
    endtask

    // WAIT_STATES=2 read of 0x1234; only the last ACCESS cycle carries 0xBEEF.
    task automatic test_read();
        logic exp_ce, exp_resp;
        bus_a.mem_address = 16'h1234;
        bus_a.mem_read = 1'b1;
        bus_a.sram_rdata = 16'h1111;
        for (int k = 1; k <= 6; k++) begin
            step();
            bus_a.sram_rdata = (k == 3) ? 16'hBEEF : 16'h1111;
            exp_ce = (k >= 1 && k <= 3);
            exp_resp = (k == 4);
            n_vec++;
            if (bus_a.sram_ce !== exp_ce) begin
                n_err++;
                $display("FAIL read_ce k=%0d: got %b required %b", k, bus_a.sram_ce, exp_ce);
            end
            n_vec++;
            if (bus_a.mem_resp !== exp_resp) begin
                n_err++;
                $display("FAIL read_resp k=%0d: got %b required %b", k, bus_a.mem_resp, exp_resp);
            end
            if (exp_ce) begin
                n_vec++;
                if ({bus_a.sram_addr, bus_a.sram_we, bus_a.sram_be} !== {15'h091A, 1'b0, 2'b11}) begin
                    n_err++;
                    $display("FAIL read_strobes k=%0d: addr %h we %b be %b required 091a 0 11",
                             k, bus_a.sram_addr, bus_a.sram_we, bus_a.sram_be);
                end
            end
            if (exp_resp || k == 6) begin
                n_vec++;
                if (bus_a.mem_rdata !== 16'hBEEF) begin
                    n_err++;
                    $display("FAIL read_data k=%0d: got %h required beef", k, bus_a.mem_rdata);
                end
            end
            if (exp_resp) bus_a.mem_read = 1'b0;
        end
    endtask

    task automatic test_write();
        logic exp_ce, exp_resp;
        bus_a.mem_address = 16'h3001;
        bus_a.mem_byte_enable = 2'b10;
        bus_a.mem_wdata = 16'hAB00;
        bus_a.mem_write = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_ce = (k >= 1 && k <= 3);
`ifdef MEM_PORT_POSTED_WRITE_EN
            exp_resp = (k == 1);
`else
            exp_resp = (k == 4);
`endif
            n_vec++;
            if (bus_a.sram_ce !== exp_ce) begin
                n_err++;
                $display("FAIL write_ce k=%0d: got %b required %b", k, bus_a.sram_ce, exp_ce);
            end
            n_vec++;
            if (bus_a.mem_resp !== exp_resp) begin
                n_err++;
                $display("FAIL write_resp k=%0d: got %b required %b", k, bus_a.mem_resp, exp_resp);
            end
            if (exp_ce) begin
                n_vec++;
                if ({bus_a.sram_addr, bus_a.sram_we, bus_a.sram_be, bus_a.sram_wdata} !==
                    {15'h1800, 1'b1, 2'b10, 16'hAB00}) begin
                    n_err++;
                    $display("FAIL write_strobes k=%0d: addr %h we %b be %b wdata %h required 1800 1 10 ab00",
                             k, bus_a.sram_addr, bus_a.sram_we, bus_a.sram_be, bus_a.sram_wdata);
                end
            end
            if (exp_resp) bus_a.mem_write = 1'b0;
        end
        bus_a.mem_byte_enable = '0;
        bus_a.mem_wdata = '0;
    endtask

    // WAIT_STATES=0: second read is presented during RESP of the first.
    task automatic test_back_to_back();
        logic exp_ce, exp_resp;
        bus_b.mem_address = 16'h0000;
        bus_b.mem_read = 1'b1;
        bus_b.sram_rdata = 16'h5A5A;
        for (int k = 1; k <= 7; k++) begin
            step();
            bus_b.sram_rdata = (k == 4) ? 16'hC3C3 : 16'h5A5A;
            exp_ce = (k == 1 || k == 4);
            exp_resp = (k == 2 || k == 5);
            n_vec++;
            if (bus_b.sram_ce !== exp_ce) begin
                n_err++;
                $display("FAIL b2b_ce k=%0d: got %b required %b", k, bus_b.sram_ce, exp_ce);
            end
            n_vec++;
            if (bus_b.mem_resp !== exp_resp) begin
                n_err++;
                $display("FAIL b2b_resp k=%0d: got %b required %b", k, bus_b.mem_resp, exp_resp);
            end
            if (k == 4) begin
                n_vec++;
                if (bus_b.sram_addr !== 15'h0001) begin
                    n_err++;
                    $display("FAIL b2b_addr: got %h required 0001", bus_b.sram_addr);
                end
            end
            if (k == 2) begin
                n_vec++;
                if (bus_b.mem_rdata !== 16'h5A5A) begin
                    n_err++;
                    $display("FAIL b2b_data0: got %h required 5a5a", bus_b.mem_rdata);
                end
                bus_b.mem_address = 16'h0002;
            end
            if (k == 5) begin
                n_vec++;
                if (bus_b.mem_rdata !== 16'hC3C3) begin
                    n_err++;
                    $display("FAIL b2b_data1: got %h required c3c3", bus_b.mem_rdata);
                end
                bus_b.mem_read = 1'b0;
            end
        end
    endtask

    task automatic test_reset_abort();
        logic exp_ce, exp_resp;
        bus_a.mem_address = 16'h0080;
        bus_a.mem_read = 1'b1;
        step();
        step();
        n_vec++;
        if (bus_a.sram_ce !== 1'b1) begin
            n_err++;
            $display("FAIL abort_pre_ce: got %b required 1", bus_a.sram_ce);
        end
        reset = 1'b1;
        step();
        n_vec++;
        if ({bus_a.sram_ce, bus_a.mem_resp, bus_a.mem_rdata} !== 18'h0) begin
            n_err++;
            $display("FAIL abort_post: ce %b resp %b rdata %h required 0 0 0000",
                     bus_a.sram_ce, bus_a.mem_resp, bus_a.mem_rdata);
        end
        reset = 1'b0;
        bus_a.mem_address = 16'h0040;
        bus_a.sram_rdata = 16'h0F0F;
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_ce = (k >= 1 && k <= 3);
            exp_resp = (k == 4);
            n_vec++;
            if ({bus_a.sram_ce, bus_a.mem_resp} !== {exp_ce, exp_resp}) begin
                n_err++;
                $display("FAIL abort_retry k=%0d: ce/resp got %b%b required %b%b",
                         k, bus_a.sram_ce, bus_a.mem_resp, exp_ce, exp_resp);
            end
            if (exp_ce) begin
                n_vec++;
                if (bus_a.sram_addr !== 15'h0020) begin
                    n_err++;
                    $display("FAIL abort_addr k=%0d: got %h required 0020", k, bus_a.sram_addr);
                end
            end
            if (exp_resp) begin
                n_vec++;
                if (bus_a.mem_rdata !== 16'h0F0F) begin
                    n_err++;
                    $display("FAIL abort_data: got %h required 0f0f", bus_a.mem_rdata);
                end
                bus_a.mem_read = 1'b0;
            end
        end
    endtask

    task automatic test_both_strobes();
        logic exp_ce, exp_resp;
        bus_a.mem_address = 16'h0010;
        bus_a.mem_byte_enable = 2'b01;
        bus_a.mem_wdata = 16'hDEAD;
        bus_a.mem_read = 1'b1;
        bus_a.mem_write = 1'b1;
        bus_a.sram_rdata = 16'h7E57;
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_ce = (k >= 1 && k <= 3);
            exp_resp = (k == 4);
            n_vec++;
            if ({bus_a.sram_ce, bus_a.mem_resp} !== {exp_ce, exp_resp}) begin
                n_err++;
                $display("FAIL both_timing k=%0d: ce/resp got %b%b required %b%b",
                         k, bus_a.sram_ce, bus_a.mem_resp, exp_ce, exp_resp);
            end
            if (exp_ce) begin
                n_vec++;
                if ({bus_a.sram_we, bus_a.sram_be, bus_a.sram_addr} !== {1'b0, 2'b11, 15'h0008}) begin
                    n_err++;
                    $display("FAIL both_strobes k=%0d: we %b be %b addr %h required 0 11 0008",
                             k, bus_a.sram_we, bus_a.sram_be, bus_a.sram_addr);
                end
            end
            if (exp_resp) begin
                n_vec++;
                if (bus_a.mem_rdata !== 16'h7E57) begin
                    n_err++;
                    $display("FAIL both_data: got %h required 7e57", bus_a.mem_rdata);
                end
                bus_a.mem_read = 1'b0;
                bus_a.mem_write = 1'b0;
            end
        end
    endtask

`ifdef MEM_PORT_POSTED_WRITE_EN
    task automatic test_posted_write();
        logic exp_ce, exp_resp;
        bus_a.mem_address = 16'h0100;
        bus_a.mem_byte_enable = 2'b11;
        bus_a.mem_wdata = 16'h1357;
        bus_a.mem_write = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_ce = (k >= 1 && k <= 3) || (k >= 5 && k <= 7);
            exp_resp = (k == 1 || k == 8);
            n_vec++;
            if ({bus_a.sram_ce, bus_a.mem_resp} !== {exp_ce, exp_resp}) begin
                n_err++;
                $display("FAIL posted k=%0d: ce/resp got %b%b required %b%b",
                         k, bus_a.sram_ce, bus_a.mem_resp, exp_ce, exp_resp);
            end
            if (k == 1) bus_a.mem_write = 1'b0;
            if (k == 2) begin
                bus_a.mem_address = 16'h0200;
                bus_a.mem_read = 1'b1;
            end
            if (k == 8) bus_a.mem_read = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_abort();
        test_both_strobes();
`ifdef MEM_PORT_POSTED_WRITE_EN
        test_posted_write();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
